// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG quantizer/dequantizer pair: widths,
// the luminance quantisation table and the quantizer control states.
package jpeg_pkg;

  localparam int COEF_W   = 11;
  localparam int Q_W      = 8;
  localparam int OUT_W    = 8;
  localparam int DEQ_W    = 11;
  localparam int NUM_COEF = 64;
  localparam int IDX_W    = 6;

  // Element k lives at [k*Q_W +: Q_W]; the first entry below is k=63.
  localparam logic [NUM_COEF*Q_W-1:0] LUM_QTABLE = {
    8'd16,  8'd11,  8'd10,  8'd16,  8'd24,  8'd40,  8'd51,  8'd61,
    8'd12,  8'd12,  8'd14,  8'd19,  8'd26,  8'd58,  8'd60,  8'd55,
    8'd14,  8'd13,  8'd16,  8'd24,  8'd40,  8'd57,  8'd69,  8'd56,
    8'd14,  8'd17,  8'd22,  8'd29,  8'd51,  8'd87,  8'd80,  8'd62,
    8'd18,  8'd22,  8'd37,  8'd56,  8'd68,  8'd109, 8'd103, 8'd77,
    8'd24,  8'd35,  8'd55,  8'd64,  8'd81,  8'd104, 8'd113, 8'd92,
    8'd49,  8'd64,  8'd78,  8'd87,  8'd103, 8'd121, 8'd120, 8'd101,
    8'd72,  8'd92,  8'd95,  8'd98,  8'd112, 8'd100, 8'd103, 8'd99
  };

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    DIVIDE = 3'd2,
    STORE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic logic [Q_W-1:0] qtable_entry(input logic [IDX_W-1:0] k);
    return LUM_QTABLE[k*Q_W +: Q_W];
  endfunction

endpackage

// File: rtl/quant_serial_div.sv
// Unsigned restoring divider, one quotient bit per cycle. The first bit is
// resolved on the start edge so done pulses COEF_W-1 cycles after start.
module quant_serial_div
  import jpeg_pkg::*;
(
  input  logic              Clock,
  input  logic              reset,
  input  logic              start,
  input  logic [COEF_W-1:0] dividend,
  input  logic [Q_W-1:0]    divisor,
  output logic              done,
  output logic [COEF_W-1:0] quotient
);

  localparam int CNT_W = 4;

  logic [Q_W-1:0]        rem_r;
  logic [COEF_W-1:0]     quot_r;
  logic [Q_W-1:0]        div_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  busy_r;
  logic                  done_r;
  logic [Q_W+COEF_W-1:0] step_s;

  // quot holds unconsumed dividend bits on the left, quotient bits on the right
  function automatic logic [Q_W+COEF_W-1:0] div_step(
    input logic [Q_W-1:0]    rem,
    input logic [COEF_W-1:0] quo,
    input logic [Q_W-1:0]    dvs
  );
    logic [Q_W:0] trial;
    logic [Q_W:0] diff;
    trial = {rem, quo[COEF_W-1]};
    diff  = trial - {1'b0, dvs};
    if (trial >= {1'b0, dvs}) begin
      return {diff[Q_W-1:0], quo[COEF_W-2:0], 1'b1};
    end else begin
      return {trial[Q_W-1:0], quo[COEF_W-2:0], 1'b0};
    end
  endfunction

  // One restoring step, seeded from the inputs on start
  always_comb begin
    step_s = '0;
    if (start) begin
      step_s = div_step({Q_W{1'b0}}, dividend, divisor);
    end else begin
      step_s = div_step(rem_r, quot_r, div_r);
    end
  end

  // Iteration registers and done pulse
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      rem_r  <= '0;
      quot_r <= '0;
      div_r  <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      {rem_r, quot_r} <= step_s;
      div_r  <= divisor;
      cnt_r  <= 4'd1;
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (busy_r) begin
      {rem_r, quot_r} <= step_s;
      if (cnt_r == CNT_W'(COEF_W - 1)) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        cnt_r  <= cnt_r + 4'd1;
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign done     = done_r;
  assign quotient = quot_r;

endmodule

// File: rtl/jpeg_quantizer.sv
// Forward JPEG quantizer: divides a latched 8x8 block by the luminance table
// one element at a time, rounding half away from zero, saturating to 8 bits.
module jpeg_quantizer
  import jpeg_pkg::*;
(
  input  logic                       Clock,
  input  logic                       reset,
  input  logic                       Enable,
  input  logic [NUM_COEF*COEF_W-1:0] A,
  output logic [NUM_COEF*OUT_W-1:0]  C,
  output logic                       done
);

  localparam logic [IDX_W-1:0] LAST_K = 6'd63;

  state_t                     state_r;
  state_t                     state_s;
  logic [IDX_W-1:0]           k_r;
  logic [NUM_COEF*COEF_W-1:0] a_r;
  logic [NUM_COEF*OUT_W-1:0]  buf_r;
  logic                       div_start_s;
  logic                       div_done_s;
  logic [COEF_W-1:0]          div_quot_s;
  logic [COEF_W-1:0]          coef_s;
  logic [COEF_W-1:0]          mag_s;
  logic [COEF_W-1:0]          m_s;
  logic [Q_W-1:0]             q_s;
  logic [OUT_W-1:0]           result_s;

  quant_serial_div u_div (
    .Clock    (Clock),
    .reset    (reset),
    .start    (div_start_s),
    .dividend (m_s),
    .divisor  (q_s),
    .done     (div_done_s),
    .quotient (div_quot_s)
  );

  // Rounded dividend: |a| + Q/2 (|-1024| still fits unsigned 11 bits)
  always_comb begin
    coef_s = a_r[k_r*COEF_W +: COEF_W];
    q_s    = qtable_entry(k_r);
    if (coef_s[COEF_W-1]) begin
      mag_s = ~coef_s + 11'd1;
    end else begin
      mag_s = coef_s;
    end
    m_s = mag_s + {{(COEF_W-Q_W+1){1'b0}}, q_s[Q_W-1:1]};
  end

  // Restore sign and saturate to the output range
  always_comb begin
    result_s = '0;
    if (coef_s[COEF_W-1]) begin
      if (div_quot_s > 11'd128) begin
        result_s = 8'h80;
      end else begin
        result_s = ~div_quot_s[OUT_W-1:0] + 8'd1;
      end
    end else begin
      if (div_quot_s > 11'd127) begin
        result_s = 8'h7F;
      end else begin
        result_s = div_quot_s[OUT_W-1:0];
      end
    end
  end

  // Control state register
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and divider start; Enable low anywhere returns to IDLE
  always_comb begin
    state_s     = state_r;
    div_start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (Enable) state_s = ISSUE;
        else        state_s = IDLE;
      end
      ISSUE: begin
        if (!Enable) begin
          state_s = IDLE;
        end else begin
          div_start_s = 1'b1;
          state_s     = DIVIDE;
        end
      end
      DIVIDE: begin
        if (!Enable)         state_s = IDLE;
        else if (div_done_s) state_s = STORE;
        else                 state_s = DIVIDE;
      end
      STORE: begin
        if (!Enable)             state_s = IDLE;
        else if (k_r == LAST_K)  state_s = DONE;
        else                     state_s = ISSUE;
      end
      DONE: begin
        if (!Enable) state_s = IDLE;
        else         state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Block latch, element index, result buffer and outputs
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      a_r   <= '0;
      k_r   <= '0;
      buf_r <= '0;
      C     <= '0;
      done  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (Enable) begin
            a_r <= A;
            k_r <= '0;
          end
        end
        STORE: begin
          if (Enable) begin
            buf_r[k_r*OUT_W +: OUT_W] <= result_s;
            if (k_r == LAST_K) begin
              // Last element goes straight to C alongside the buffered 63
              C    <= {result_s, buf_r[(NUM_COEF-1)*OUT_W-1:0]};
              done <= 1'b1;
            end else begin
              k_r <= k_r + 6'd1;
            end
          end
        end
        DONE: begin
          if (!Enable) done <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_quantizer.sv
// Directed bench for jpeg_quantizer: table-driven element vectors plus
// abort, asynchronous reset and hold/restart sequences.
module tb_jpeg_quantizer;

  logic         Clock = 1'b0;
  logic         reset;
  logic         Enable;
  logic [703:0] A;
  logic [511:0] C;
  logic         done;

  int checks = 0;
  int errors = 0;

  int qtab [64] = '{
     99, 103, 100, 112,  98,  95,  92,  72,
    101, 120, 121, 103,  87,  78,  64,  49,
     92, 113, 104,  81,  64,  55,  35,  24,
     77, 103, 109,  68,  56,  37,  22,  18,
     62,  80,  87,  51,  29,  22,  17,  14,
     56,  69,  57,  40,  24,  16,  13,  14,
     55,  60,  58,  26,  19,  14,  12,  12,
     61,  51,  40,  24,  16,  10,  11,  16
  };

  typedef struct {
    int blk;
    int k;
    int a;
    int expv;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  always #5 Clock = ~Clock;

  jpeg_quantizer dut (
    .Clock  (Clock),
    .reset  (reset),
    .Enable (Enable),
    .A      (A),
    .C      (C),
    .done   (done)
  );

  function automatic int elem(input logic [511:0] cv, input int k);
    logic [7:0] b;
    b = cv[k*8 +: 8];
    return int'($signed(b));
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_vec(input string name, input logic [511:0] act, input logic [511:0] req);
    int bad;
    int first;
    bad = 0;
    first = -1;
    for (int k = 0; k < 64; k++) begin
      if (act[k*8 +: 8] !== req[k*8 +: 8]) begin
        bad++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d elements differ, first k=%0d got %0d, required %0d",
               name, bad, first, elem(act, first), elem(req, first));
    end
  endtask

  task automatic set_elem(input int k, input int a);
    logic [31:0] t;
    t = a;
    A[k*11 +: 11] = t[10:0];
  endtask

  function automatic logic [511:0] put_elem(input logic [511:0] cv, input int k, input int v);
    logic [31:0] t;
    logic [511:0] r;
    t = v;
    r = cv;
    r[k*8 +: 8] = t[7:0];
    return r;
  endfunction

  function automatic logic [511:0] all_same(input int v);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 64; k++) r = put_elem(r, k, v);
    return r;
  endfunction

  task automatic fill_mult(input int mult);
    for (int k = 0; k < 64; k++) set_elem(k, mult * qtab[k]);
  endtask

  // Raise Enable and count edges until done; optionally disturb A after latch
  task automatic run_block(input string name, input bit scramble);
    int edges;
    @(negedge Clock);
    Enable = 1'b1;
    edges = 0;
    for (int n = 0; n < 1000; n++) begin
      @(posedge Clock);
      #1;
      edges++;
      if (scramble && edges == 5) A = ~A;
      if (done) break;
    end
    check({name, "_done_edge"}, edges, 833);
  endtask

  task automatic ack(input string name);
    @(negedge Clock);
    Enable = 1'b0;
    @(posedge Clock);
    #1;
    check({name, "_ack_done"}, int'(done), 0);
  endtask

  logic [511:0] exp_c;
  logic [511:0] prev_c;
  int           bad_hold;
  int           deq_bad;

  initial begin
    vecs[0]  = '{0,  0,    50,   1};
    vecs[1]  = '{0, 61,    15,   2};
    vecs[2]  = '{0, 63, -1024, -64};
    vecs[3]  = '{0,  1,   -52,  -1};
    vecs[4]  = '{0,  8,   101,   1};
    vecs[5]  = '{0, 15,   -25,  -1};
    vecs[6]  = '{1,  0,    49,   0};
    vecs[7]  = '{1, 63,  1023,  64};
    vecs[8]  = '{1, 61,    14,   1};
    vecs[9]  = '{1,  2, -1024, -10};
    vecs[10] = '{1, 32,    31,   1};
    vecs[11] = '{1, 33,   -40,  -1};
    vecs[12] = '{2,  0,   -50,  -1};
    vecs[13] = '{2, 61,   -15,  -2};
    vecs[14] = '{2, 63,    -8,  -1};
    vecs[15] = '{2, 30,   -11,  -1};
    vecs[16] = '{2, 31,     8,   0};

    reset  = 1'b1;
    Enable = 1'b0;
    A      = '0;
    #12;
    check_vec("reset_C", C, '0);
    check("reset_done", int'(done), 0);
    @(negedge Clock);
    reset = 1'b0;

    // Table-driven blocks
    exp_c = '0;
    for (int b = 0; b < 3; b++) begin
      A = '0;
      exp_c = '0;
      for (int i = 0; i < NVEC; i++) begin
        if (vecs[i].blk == b) begin
          set_elem(vecs[i].k, vecs[i].a);
          exp_c = put_elem(exp_c, vecs[i].k, vecs[i].expv);
        end
      end
      run_block($sformatf("blk%0d", b), 1'b0);
      for (int i = 0; i < NVEC; i++) begin
        if (vecs[i].blk == b)
          check($sformatf("blk%0d_k%0d", b, vecs[i].k), elem(C, vecs[i].k), vecs[i].expv);
      end
      check_vec($sformatf("blk%0d_full", b), C, exp_c);
      ack($sformatf("blk%0d", b));
    end
    prev_c = exp_c;

    // Abort at edge 400: C keeps the previous block
    fill_mult(3);
    @(negedge Clock);
    Enable = 1'b1;
    repeat (399) @(posedge Clock);
    @(negedge Clock);
    Enable = 1'b0;
    @(posedge Clock);
    #1;
    check("abort_done", int'(done), 0);
    check_vec("abort_C", C, prev_c);
    repeat (20) @(posedge Clock);
    #1;
    check("abort_done_later", int'(done), 0);
    check_vec("abort_C_later", C, prev_c);

    // Restart with fresh A (disturbed after latch): 3 everywhere
    fill_mult(3);
    run_block("restart", 1'b1);
    check_vec("restart_C", C, all_same(3));
    check("deq_k63", elem(C, 63) * qtab[63], 48);
    deq_bad = 0;
    for (int k = 0; k < 64; k++)
      if (elem(C, k) * qtab[k] != 3 * qtab[k]) deq_bad++;
    check("deq_all", deq_bad, 0);
    ack("restart");

    // Asynchronous reset mid-operation
    fill_mult(1);
    @(negedge Clock);
    Enable = 1'b1;
    repeat (499) @(posedge Clock);
    #3;
    reset = 1'b1;
    #1;
    check_vec("midreset_C", C, '0);
    check("midreset_done", int'(done), 0);
    @(negedge Clock);
    reset  = 1'b0;
    Enable = 1'b0;
    run_block("postreset", 1'b0);
    check_vec("postreset_C", C, all_same(1));

    // Hold Enable after done: outputs stable, no restart
    bad_hold = 0;
    for (int n = 0; n < 50; n++) begin
      @(posedge Clock);
      #1;
      if (C !== all_same(1) || done !== 1'b1) bad_hold++;
    end
    check("hold_stable", bad_hold, 0);
    @(negedge Clock);
    Enable = 1'b0;
    @(posedge Clock);
    #1;
    check("pulse_done_low", int'(done), 0);
    check_vec("pulse_C_kept", C, all_same(1));

    fill_mult(-2);
    run_block("second", 1'b0);
    check_vec("second_C", C, all_same(-2));
    ack("second");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
